// File: rtl/video_hv_timing.sv
// video_hv_timing: prescaler edge detector driving H/V counters, sync, blank and line/frame strobes
module video_hv_timing #(
   parameter int DIV_SEL      = 0,
   parameter int H_W          = 9,
   parameter int V_W          = 9,
   parameter int H_TOTAL      = 456,
   parameter int H_ACTIVE     = 336,
   parameter int H_SYNC_START = 360,
   parameter int H_SYNC_END   = 392,
   parameter int V_TOTAL      = 262,
   parameter int V_ACTIVE     = 240,
   parameter int V_SYNC_START = 245,
   parameter int V_SYNC_END   = 248
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     div_q,
   input  logic           run,
   output logic           pix_en,
   output logic [H_W-1:0] h_cnt,
   output logic [V_W-1:0] v_cnt,
   output logic           hblank,
   output logic           vblank,
   output logic           hsync_b,
   output logic           vsync_b,
   output logic           line_start,
   output logic           frame_start
);
   if (DIV_SEL < 0 || DIV_SEL > 3 || H_TOTAL < 1 || H_TOTAL > 2**H_W || V_TOTAL < 1 || V_TOTAL > 2**V_W ||
       H_ACTIVE > 2**H_W || H_SYNC_START > 2**H_W || H_SYNC_END > 2**H_W ||
       V_ACTIVE > 2**V_W || V_SYNC_START > 2**V_W || V_SYNC_END > 2**V_W) begin : g_bad_params
      $error("video_hv_timing: illegal parameter set");
   end
   localparam logic [1:0]     SEL    = 2'(DIV_SEL);
   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
   // decode thresholds carry one spare bit so a limit equal to 2**W still compares correctly
   localparam logic [H_W:0]   H_ACT  = (H_W+1)'(H_ACTIVE);
   localparam logic [H_W:0]   H_SS   = (H_W+1)'(H_SYNC_START);
   localparam logic [H_W:0]   H_SE   = (H_W+1)'(H_SYNC_END);
   localparam logic [V_W:0]   V_ACT  = (V_W+1)'(V_ACTIVE);
   localparam logic [V_W:0]   V_SS   = (V_W+1)'(V_SYNC_START);
   localparam logic [V_W:0]   V_SE   = (V_W+1)'(V_SYNC_END);
   logic [3:0]     q_r, q_p;
   logic           adv, h_wrap, v_wrap;
   logic [H_W-1:0] h_nxt;
   logic [V_W-1:0] v_nxt;
   logic [H_W:0]   h_ext;
   logic [V_W:0]   v_ext;
   // two-stage sample of the prescaler; reset to all ones so a high input is not seen as an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r    <= 4'hF;
         q_p    <= 4'hF;
         pix_en <= 1'b0;
      end else begin
         q_r    <= div_q;
         q_p    <= q_r;
         pix_en <= q_r[SEL] & ~q_p[SEL];
      end
   end
   // next counts: advance only on a pixel enable while running, wrapping at the line/frame ends
   always_comb begin
      adv    = pix_en & run;
      h_wrap = adv & (h_cnt == H_LAST);
      v_wrap = h_wrap & (v_cnt == V_LAST);
      h_nxt  = !adv ? h_cnt : h_wrap ? '0 : h_cnt + 1'b1;
      v_nxt  = !h_wrap ? v_cnt : v_wrap ? '0 : v_cnt + 1'b1;
      h_ext  = {1'b0, h_nxt};
      v_ext  = {1'b0, v_nxt};
   end
   // counters, decodes from the next counts so they align with h_cnt/v_cnt, and wrap strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         hblank      <= 1'b0;
         vblank      <= 1'b0;
         hsync_b     <= 1'b1;
         vsync_b     <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         hblank      <= h_ext >= H_ACT;
         vblank      <= v_ext >= V_ACT;
         hsync_b     <= !(h_ext >= H_SS && h_ext < H_SE);
         vsync_b     <= !(v_ext >= V_SS && v_ext < V_SE);
         line_start  <= h_wrap;
         frame_start <= v_wrap;
      end
   end
endmodule

// File: tb/tb_video_hv_timing.sv
// tb_video_hv_timing: randomized and directed checks of two timing generator instances against a pixel-position model
module tb_video_hv_timing;
   localparam int HT[2]  = '{456, 20};
   localparam int HA[2]  = '{336, 12};
   localparam int HSS[2] = '{360, 14};
   localparam int HSE[2] = '{392, 16};
   localparam int VT[2]  = '{262, 10};
   localparam int VA[2]  = '{240, 6};
   localparam int VSS[2] = '{245, 7};
   localparam int VSE[2] = '{248, 8};
   localparam int SEL[2] = '{0, 2};
   localparam logic [24:0] RST_VEC = {1'b0, 9'd0, 9'd0, 4'b0011, 2'b00};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [3:0] div_q = 4'hF;
   logic [1:0] pix_o, hb_o, vb_o, hs_o, vs_o, ls_o, fs_o;
   logic [8:0] h_o[2];
   logic [8:0] v_o[2];
   int n_cmp = 0;
   int n_bad = 0;
   int pc = 0;

   always #5 clk = ~clk;

   video_hv_timing u_main (
      .clk(clk), .rst(rst), .div_q(div_q), .run(run),
      .pix_en(pix_o[0]), .h_cnt(h_o[0]), .v_cnt(v_o[0]),
      .hblank(hb_o[0]), .vblank(vb_o[0]), .hsync_b(hs_o[0]), .vsync_b(vs_o[0]),
      .line_start(ls_o[0]), .frame_start(fs_o[0])
   );

   video_hv_timing #(
      .DIV_SEL(2), .H_W(9), .V_W(9),
      .H_TOTAL(20), .H_ACTIVE(12), .H_SYNC_START(14), .H_SYNC_END(16),
      .V_TOTAL(10), .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_END(8)
   ) u_small (
      .clk(clk), .rst(rst), .div_q(div_q), .run(run),
      .pix_en(pix_o[1]), .h_cnt(h_o[1]), .v_cnt(v_o[1]),
      .hblank(hb_o[1]), .vblank(vb_o[1]), .hsync_b(hs_o[1]), .vsync_b(vs_o[1]),
      .line_start(ls_o[1]), .frame_start(fs_o[1])
   );

   // reference: sampled input history plus an absolute pixel position within the frame
   logic [3:0] hist[3];
   int         m_n[2];
   logic       m_pix[2], m_ls[2], m_fs[2];
   always @(posedge clk) begin
      if (rst) begin
         hist = '{4'hF, 4'hF, 4'hF};
         for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_pix[i] = 1'b0; m_ls[i] = 1'b0; m_fs[i] = 1'b0;
         end
      end else begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = div_q;
         for (int i = 0; i < 2; i++) begin
            m_ls[i] = 1'b0;
            m_fs[i] = 1'b0;
            if (m_pix[i] && run) begin
               m_n[i] = (m_n[i] + 1) % (HT[i] * VT[i]);
               m_ls[i] = (m_n[i] % HT[i]) == 0;
               m_fs[i] = m_n[i] == 0;
            end
            m_pix[i] = hist[1][SEL[i]] && !hist[2][SEL[i]];
         end
      end
   end

   function automatic logic [24:0] exp_vec(int i);
      int h = m_n[i] % HT[i];
      int v = m_n[i] / HT[i];
      return {m_pix[i], 9'(h), 9'(v), h >= HA[i], v >= VA[i],
              !(h >= HSS[i] && h < HSE[i]), !(v >= VSS[i] && v < VSE[i]), m_ls[i], m_fs[i]};
   endfunction

   function automatic logic [24:0] act_vec(int i);
      return {pix_o[i], h_o[i], v_o[i], hb_o[i], vb_o[i], hs_o[i], vs_o[i], ls_o[i], fs_o[i]};
   endfunction

   task automatic adv_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic ps_step(input int sh);
      pc++;
      div_q = 4'(pc >> sh);
      adv_clk();
   endtask

   task automatic test_reset();
      rst = 1'b1; div_q = 4'hF; run = 1'b1;
      repeat (3) adv_clk();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (act_vec(i) !== RST_VEC) begin
            n_bad++; $display("FAIL reset[%0d] got=%h exp=%h", i, act_vec(i), RST_VEC);
         end
      end
      rst = 1'b0;
      repeat (20) begin
         adv_clk();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({pix_o[i], h_o[i]} !== 10'd0) begin
               n_bad++; $display("FAIL hold_high[%0d] pix=%b h=%0d exp pix=0 h=0", i, pix_o[i], h_o[i]);
            end
         end
      end
   endtask

   task automatic test_pix_en();
      pc = 0;
      for (int k = 1; k <= 64; k++) begin
         ps_step(1);
         n_cmp++;
         if (pix_o[0] !== (k % 4 == 3)) begin
            n_bad++; $display("FAIL pix_period k=%0d got=%b exp=%b", k, pix_o[0], k % 4 == 3);
         end
         n_cmp++;
         if (h_o[0] !== 9'(k / 4)) begin
            n_bad++; $display("FAIL h_step k=%0d got=%0d exp=%0d", k, h_o[0], k / 4);
         end
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (act_vec(i) !== exp_vec(i)) begin
               n_bad++; $display("FAIL pix_vec[%0d] got=%h exp=%h", i, act_vec(i), exp_vec(i));
            end
         end
      end
   endtask

   task automatic test_line_wrap();
      int t = 0;
      while (!(m_pix[0] && m_n[0] % HT[0] == HT[0] - 1) && t < 4000) begin
         ps_step(0);
         t++;
      end
      n_cmp++;
      if (t >= 4000) begin
         n_bad++; $display("FAIL line_wrap_timeout got=%0d ticks exp<4000", t);
      end
      ps_step(0);
      n_cmp++;
      if ({h_o[0], v_o[0], ls_o[0], fs_o[0]} !== {9'd0, 9'd1, 2'b10}) begin
         n_bad++; $display("FAIL line_wrap h=%0d v=%0d ls=%b fs=%b exp h=0 v=1 ls=1 fs=0",
                           h_o[0], v_o[0], ls_o[0], fs_o[0]);
      end
      ps_step(0);
      n_cmp++;
      if (ls_o[0] !== 1'b0) begin
         n_bad++; $display("FAIL line_pulse_width got=%b exp=0", ls_o[0]);
      end
   endtask

   task automatic test_sweep();
      bit [455:0] hs_low = '0, hb_hi = '0, vis_h = '0, e_hs = '0, e_hb = '0;
      bit [19:0]  s_hs = '0, s_hb = '0, s_vis_h = '0, se_hs = '0, se_hb = '0;
      bit [9:0]   s_vs = '0, s_vb = '0, s_vis_v = '0, se_vs = '0, se_vb = '0;
      for (int t = 0; t < 2000; t++) begin
         ps_step(0);
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (act_vec(i) !== exp_vec(i)) begin
               n_bad++; $display("FAIL sweep_vec[%0d] got=%h exp=%h", i, act_vec(i), exp_vec(i));
            end
         end
         if (h_o[0] < 456) begin
            vis_h[h_o[0]] = 1'b1; hs_low[h_o[0]] |= !hs_o[0]; hb_hi[h_o[0]] |= hb_o[0];
         end
         if (h_o[1] < 20) begin
            s_vis_h[h_o[1]] = 1'b1; s_hs[h_o[1]] |= !hs_o[1]; s_hb[h_o[1]] |= hb_o[1];
         end
         if (v_o[1] < 10) begin
            s_vis_v[v_o[1]] = 1'b1; s_vs[v_o[1]] |= !vs_o[1]; s_vb[v_o[1]] |= vb_o[1];
         end
      end
      for (int h = 0; h < 456; h++) begin
         e_hs[h] = h >= 360 && h <= 391; e_hb[h] = h >= 336;
      end
      for (int h = 0; h < 20; h++) begin
         se_hs[h] = h >= 14 && h <= 15; se_hb[h] = h >= 12;
      end
      for (int v = 0; v < 10; v++) begin
         se_vs[v] = v == 7; se_vb[v] = v >= 6;
      end
      n_cmp++;
      if (hs_low !== e_hs || ~vis_h != '0) begin
         n_bad++; $display("FAIL hsync_range got=%h exp=%h", hs_low, e_hs);
      end
      n_cmp++;
      if (hb_hi !== e_hb) begin
         n_bad++; $display("FAIL hblank_range got=%h exp=%h", hb_hi, e_hb);
      end
      n_cmp++;
      if ({s_hs, s_hb} !== {se_hs, se_hb} || ~s_vis_h != '0) begin
         n_bad++; $display("FAIL small_h_range got=%h exp=%h", {s_hs, s_hb}, {se_hs, se_hb});
      end
      n_cmp++;
      if ({s_vs, s_vb} !== {se_vs, se_vb} || ~s_vis_v != '0) begin
         n_bad++; $display("FAIL small_v_range got=%h exp=%h", {s_vs, s_vb}, {se_vs, se_vb});
      end
   endtask

   task automatic test_frame_wrap();
      int t = 0;
      while (!(m_pix[1] && m_n[1] == HT[1] * VT[1] - 1) && t < 3000) begin
         ps_step(0);
         t++;
      end
      n_cmp++;
      if (t >= 3000 || vb_o[1] !== 1'b1) begin
         n_bad++; $display("FAIL frame_pre t=%0d vblank=%b exp vblank=1 t<3000", t, vb_o[1]);
      end
      ps_step(0);
      n_cmp++;
      if ({h_o[1], v_o[1], ls_o[1], fs_o[1], vb_o[1]} !== {9'd0, 9'd0, 3'b110}) begin
         n_bad++; $display("FAIL frame_wrap h=%0d v=%0d ls=%b fs=%b vb=%b exp 0 0 1 1 0",
                           h_o[1], v_o[1], ls_o[1], fs_o[1], vb_o[1]);
      end
      ps_step(0);
      n_cmp++;
      if ({ls_o[1], fs_o[1]} !== 2'b00) begin
         n_bad++; $display("FAIL frame_pulse_width got=%b exp=00", {ls_o[1], fs_o[1]});
      end
   endtask

   task automatic test_reset_mid();
      int t = 0;
      while (m_n[0] % HT[0] != 200 && t < 2000) begin
         ps_step(0);
         t++;
      end
      n_cmp++;
      if (t >= 2000) begin
         n_bad++; $display("FAIL reset_mid_timeout got=%0d ticks exp<2000", t);
      end
      rst = 1'b1;
      ps_step(0);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (act_vec(i) !== RST_VEC) begin
            n_bad++; $display("FAIL reset_mid[%0d] got=%h exp=%h", i, act_vec(i), RST_VEC);
         end
      end
      repeat (8) begin
         ps_step(0);
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (act_vec(i) !== exp_vec(i)) begin
               n_bad++; $display("FAIL post_reset[%0d] got=%h exp=%h", i, act_vec(i), exp_vec(i));
            end
         end
      end
   endtask

   task automatic test_run_hold();
      int pulses = 0;
      int t = 0;
      logic [8:0] h_hold = 9'(m_n[0] % HT[0]);
      run = 1'b0;
      while (pulses < 10 && t < 200) begin
         ps_step(0);
         t++;
         pulses += int'(pix_o[0]);
         n_cmp++;
         if (h_o[0] !== h_hold || ls_o[0] !== 1'b0) begin
            n_bad++; $display("FAIL run_hold h=%0d ls=%b exp h=%0d ls=0", h_o[0], ls_o[0], h_hold);
         end
      end
      n_cmp++;
      if (pulses != 10) begin
         n_bad++; $display("FAIL run_hold_pulses got=%0d exp=10", pulses);
      end
      run = 1'b1;
   endtask

   task automatic test_random();
      for (int t = 0; t < 3000; t++) begin
         div_q = 4'($urandom);
         run = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 199) == 0;
         adv_clk();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (act_vec(i) !== exp_vec(i)) begin
               n_bad++; $display("FAIL random[%0d] t=%0d got=%h exp=%h", i, t, act_vec(i), exp_vec(i));
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pix_en();
      test_line_wrap();
      test_sweep();
      test_frame_wrap();
      test_reset_mid();
      test_run_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
